// File: rtl/wb_unit_if.sv
// Write-back unit bus: execute/memory-side inputs, register-file write port
// and issue-stage scoreboard outputs.
interface wb_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                 alu_valid;
  logic [ADDR_W-1:0]    alu_rd;
  logic [DATA_W-1:0]    alu_data;
  logic                 ld_valid;
  logic                 ld_ready;
  logic [ADDR_W-1:0]    ld_rd;
  logic [DATA_W-1:0]    ld_data;
  logic                 issue_ld;
  logic [ADDR_W-1:0]    issue_rd;
  logic [2**ADDR_W-1:0] busy;
  logic                 stall_req;
  logic                 we;
  logic [ADDR_W-1:0]    waddr;
  logic [DATA_W-1:0]    wdata;

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, issue_ld, issue_rd,
    output ld_ready, busy, stall_req, we, waddr, wdata
  );

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, issue_ld, issue_rd,
    input  ld_ready, busy, stall_req, we, waddr, wdata
  );
endinterface

// File: rtl/wb_unit.sv
// Register-file write-port owner: ALU results take priority, load responses
// queue in a small FIFO, and a busy scoreboard tracks outstanding loads.
module wb_unit #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  wb_unit_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 2**ADDR_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [ADDR_W-1:0] fifo_rd_q   [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              alu_win, enq, deq;
  logic [ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0] head_data;

  assign head_rd   = fifo_rd_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];

  // An ALU result to x0 does not claim the port, so the FIFO may drain under it.
  assign alu_win = bus.alu_valid && (bus.alu_rd != '0);
  assign enq     = bus.ld_valid && bus.ld_ready;
  assign deq     = !alu_win && (count_q != '0);
  assign count_d = count_q + CNT_W'(enq) - CNT_W'(deq);

  assign bus.ld_ready  = rst && (count_q < FULL_CNT);
  assign bus.stall_req = (count_q == FULL_CNT);
  assign bus.busy      = busy_q;
  assign bus.we        = we_q;
  assign bus.waddr     = waddr_q;
  assign bus.wdata     = wdata_q;

  always_comb begin
    we_d    = 1'b0;
    waddr_d = '0;
    wdata_d = '0;
    busy_d  = busy_q;
    if (alu_win) begin
      we_d    = 1'b1;
      waddr_d = bus.alu_rd;
      wdata_d = bus.alu_data;
    end else if (deq && (head_rd != '0)) begin
      we_d            = 1'b1;
      waddr_d         = head_rd;
      wdata_d         = head_data;
      busy_d[head_rd] = 1'b0;
    end
    // A new issue to the same register outranks the clear of the older load.
    if (bus.issue_ld && (bus.issue_rd != '0)) begin
      busy_d[bus.issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_rd_q[wr_ptr_q]   <= bus.ld_rd;
      fifo_data_q[wr_ptr_q] <= bus.ld_data;
    end
  end
endmodule

// File: tb/tb_wb_unit.sv
// Directed and randomized bench for wb_unit against a queue-based model of
// the write-port arbitration and load scoreboard.
module tb_wb_unit;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ld_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  ld_t        mq[$];
  logic [31:0] m_busy;
  logic        m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;

  wb_unit_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  wb_unit #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
    bus.ld_valid  = 1'b0;
    bus.ld_rd     = '0;
    bus.ld_data   = '0;
    bus.issue_ld  = 1'b0;
    bus.issue_rd  = '0;
  endtask

  // One clock cycle: drive inputs, predict, clock, compare registered outputs.
  task automatic cyc(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                     input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld,
                     input logic iv, input logic [AW-1:0] ird, output logic acc);
    ld_t h;
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = ad;
    bus.ld_valid  = lv;
    bus.ld_rd     = lrd;
    bus.ld_data   = ld;
    bus.issue_ld  = iv;
    bus.issue_rd  = ird;
    #1;
    chk("ld_ready", 64'(bus.ld_ready), 64'(mq.size() < DEPTH));
    chk("stall_req", 64'(bus.stall_req), 64'(mq.size() == DEPTH));
    acc     = lv && (mq.size() < DEPTH);
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    if (av && ard != 0) begin
      m_we    = 1'b1;
      m_waddr = ard;
      m_wdata = ad;
    end else if (mq.size() != 0) begin
      h = mq.pop_front();
      if (h.rd != 0) begin
        m_we          = 1'b1;
        m_waddr       = h.rd;
        m_wdata       = h.data;
        m_busy[h.rd]  = 1'b0;
      end
    end
    if (acc) mq.push_back({lrd, ld});
    if (iv && ird != 0) m_busy[ird] = 1'b1;
    @(posedge clk);
    #1;
    chk("we", 64'(bus.we), 64'(m_we));
    if (m_we) begin
      chk("waddr", 64'(bus.waddr), 64'(m_waddr));
      chk("wdata", 64'(bus.wdata), 64'(m_wdata));
    end
    chk("busy", 64'(bus.busy), 64'(m_busy));
  endtask

  initial begin
    logic acc;
    int   sent;
    int   guard;
    logic av;
    n_cmp  = 0;
    n_err  = 0;
    m_busy = '0;
    rst    = 1'b0;
    idle_inputs();

    // Reset values at power-up.
    #1;
    chk("rst_we", 64'(bus.we), 64'(0));
    chk("rst_waddr", 64'(bus.waddr), 64'(0));
    chk("rst_wdata", 64'(bus.wdata), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_ld_ready", 64'(bus.ld_ready), 64'(0));
    chk("rst_stall", 64'(bus.stall_req), 64'(0));
    #12;
    rst = 1'b1;
    #1;
    chk("rel_ld_ready", 64'(bus.ld_ready), 64'(1));
    @(posedge clk);
    #1;

    // ALU path.
    cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, '0, acc);
    chk("alu_we", 64'(bus.we), 64'(1));
    chk("alu_waddr", 64'(bus.waddr), 64'(5));
    chk("alu_wdata", 64'(bus.wdata), 64'hDEADBEEF);
    cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, acc);
    chk("alu_one_cycle", 64'(bus.we), 64'(0));
    cyc(1'b1, 5'd0, 32'h5555AAAA, 1'b0, '0, '0, 1'b0, '0, acc);
    chk("alu_x0_no_we", 64'(bus.we), 64'(0));

    // Load path with scoreboard.
    cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7, acc);
    chk("busy7_set", 64'(bus.busy[7]), 64'(1));
    for (int i = 0; i < 2; i++) cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, acc);
    cyc(1'b0, '0, '0, 1'b1, 5'd7, 32'h1234, 1'b0, '0, acc);
    chk("ld_no_early_we", 64'(bus.we), 64'(0));
    cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, acc);
    chk("ld_wdata", 64'(bus.wdata), 64'h1234);
    chk("busy7_clear", 64'(bus.busy[7]), 64'(0));

    // Contention until full, then drain in arrival order.
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b1, 5'(1 + i), $urandom, 1'b1, 5'(20 + i), 32'(32'hA000 + i), 1'b0, '0, acc);
    chk("full_stall", 64'(bus.stall_req), 64'(1));
    chk("full_ld_ready", 64'(bus.ld_ready), 64'(0));
    cyc(1'b1, 5'd3, $urandom, 1'b1, 5'd30, 32'hBAD, 1'b0, '0, acc);
    chk("full_reject", 64'(acc), 64'(0));
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, acc);
      chk("drain_order", 64'(bus.waddr), 64'(20 + i));
    end

    // Simultaneous set and clear of the same busy bit.
    cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9, acc);
    cyc(1'b0, '0, '0, 1'b1, 5'd9, 32'h99, 1'b0, '0, acc);
    cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9, acc);
    chk("setclr_waddr", 64'(bus.waddr), 64'(9));
    chk("setclr_busy9", 64'(bus.busy[9]), 64'(1));
    cyc(1'b0, '0, '0, 1'b1, 5'd9, 32'h98, 1'b0, '0, acc);
    cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, acc);

    // Pointer wrap: 10 loads with random ALU gaps.
    sent  = 0;
    guard = 0;
    while (sent < 10 && guard < 200) begin
      av = 1'($urandom_range(0, 1)) && (mq.size() < DEPTH);
      cyc(av, 5'($urandom_range(1, 31)), $urandom, 1'b1, 5'($urandom_range(1, 31)),
          $urandom, 1'b0, '0, acc);
      if (acc) sent++;
      guard++;
    end
    chk("wrap_sent", 64'(sent), 64'(10));
    for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, acc);
    chk("wrap_drained", 64'(bus.we), 64'(0));

    // Random traffic honouring stall_req.
    for (int i = 0; i < 300; i++) begin
      av = 1'($urandom_range(0, 2) != 0) && (mq.size() < DEPTH);
      cyc(av, 5'($urandom), $urandom, 1'($urandom_range(0, 1)), 5'($urandom), $urandom,
          1'($urandom_range(0, 1)), 5'($urandom), acc);
    end

    // Reset mid-traffic with three loads buffered.
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 5'd2, $urandom, 1'b1, 5'(11 + i), $urandom, 1'b1, 5'(11 + i), acc);
    idle_inputs();
    rst = 1'b0;
    #1;
    chk("mid_rst_we", 64'(bus.we), 64'(0));
    chk("mid_rst_busy", 64'(bus.busy), 64'(0));
    chk("mid_rst_ld_ready", 64'(bus.ld_ready), 64'(0));
    chk("mid_rst_stall", 64'(bus.stall_req), 64'(0));
    mq.delete();
    m_busy = '0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rel_ld_ready", 64'(bus.ld_ready), 64'(1));
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, acc);
    chk("no_stale_we", 64'(bus.we), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/wb_unit.md
# wb_unit

Write-back unit that owns the single register-file write port (we/waddr/wdata). It merges single-cycle ALU results with variable-latency load responses, buffers loads in a small FIFO while the ALU holds the port, and keeps a busy scoreboard of registers with outstanding loads for the issue stage's hazard check. It sits between the execute/memory stages and the register file, which bypasses same-cycle writes to its read ports.

## Interface
- DATA_W, 32, data width
- ADDR_W, 5, register address width (32 registers, x0 hardwired zero)
- FIFO_DEPTH, 4, load-response buffer entries (power of two, >= 2)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; one clock, reset asynchronous and active-low
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  ADDR_W  ALU destination
- alu_data  in  DATA_W  ALU result
- ld_valid  in  1  load response offered
- ld_ready  out  1  load response accepted when ld_valid && ld_ready
- ld_rd  in  ADDR_W  load destination
- ld_data  in  DATA_W  load data
- issue_ld  in  1  load issued this cycle; marks issue_rd busy
- issue_rd  in  ADDR_W  destination of issued load
- busy  out  2**ADDR_W  per-register outstanding-load bits
- stall_req  out  1  upstream must not present alu_valid while high
- we  out  1  register-file write enable
- waddr  out  ADDR_W  register-file write address
- wdata  out  DATA_W  register-file write data

## Operation
- FIFO: FIFO_DEPTH entries of {rd, data}; write pointer, read pointer, count (0..FIFO_DEPTH); pointers wrap modulo FIFO_DEPTH.
- ld_ready = rst deasserted && count < FIFO_DEPTH (combinational, no credit for same-cycle dequeue).
- Enqueue on ld_valid && ld_ready; loads to x0 are enqueued normally and discarded at drain (their busy bit never set).
- Port arbitration each cycle (combinational select, registered output):
  - alu_valid && alu_rd != 0: ALU wins; FIFO not dequeued.
  - else if count != 0: dequeue FIFO head; write it unless head rd == 0.
  - else: no write.
- alu_valid with alu_rd == 0: no write, but still counts as "ALU wins" only if rd != 0 — i.e. port is free for FIFO.
- stall_req = (count == FIFO_DEPTH). If alu_valid arrives while stall_req high (protocol violation), ALU still wins; ALU results are never dropped.
- Enqueue and dequeue in same cycle: count unchanged.
- Scoreboard: issue_ld && issue_rd != 0 sets busy[issue_rd]; a load write to register r clears busy[r] in the cycle the write is registered into we/waddr. Set and clear of the same bit in the same cycle: set wins. busy[0] always 0.
- ALU writes never touch busy.

## Timing
- Reset (rst low, asynchronous): we=0, waddr=0, wdata=0, busy=0, count=0, pointers=0, stall_req=0, ld_ready=0. All outputs take these values immediately on assertion, independent of clk; any buffered loads are lost.
- First rising edge after rst deasserts is a normal cycle; ld_ready=1 from deassertion.
- ALU result presented in cycle N: we=1, waddr/wdata valid during cycle N+1, for exactly one cycle.
- Load accepted in cycle N: earliest write visible cycle N+2 (enters FIFO at edge ending N, selected in N+1 if no ALU write, registered at end of N+1).
- busy bit clears in the same cycle its load write appears on we/waddr (N+2 minimum); busy bit set visible the cycle after issue_ld.
- Write-port throughput: one write per cycle.
- FIFO order strictly preserved; no reordering among loads.

## Test plan
- Reset: hold rst low mid-traffic with 3 loads buffered -> we=0, busy=0, ld_ready=0 immediately; after release ld_ready=1, no stale writes.
- ALU only: alu_valid, rd=5, data=0xDEADBEEF in cycle 10 -> we=1, waddr=5, wdata=0xDEADBEEF in cycle 11 only; alu_rd=0 -> we stays 0.
- Load path: issue_ld rd=7 at cycle 2 (busy[7]=1 from cycle 3); load rd=7, data=0x1234 accepted cycle 6, no ALU -> write cycle 8, busy[7]=0 in cycle 8.
- Contention/full: ALU valid every cycle while 4 loads arrive -> ld_ready=0 and stall_req=1 after 4th; drop alu_valid -> loads written in arrival order on 4 consecutive cycles, ld_ready reasserts after first dequeue.
- Simultaneous set/clear: issue_ld rd=9 in same cycle a prior rd=9 load is drained -> busy[9] remains 1.
- Pointer wrap: stream 10 loads with random ALU gaps -> all 10 written exactly once, in order, data intact.
